// File: rtl/truth_table_scanner_if.sv
// rtl/truth_table_scanner_if.sv - scanner control/result bundle between a host and truth_table_scanner
interface truth_table_scanner_if;
  logic       start;
  logic       f_in;
  logic [7:0] expected;
  logic [2:0] abc;
  logic [7:0] tt;
  logic [3:0] ones;
  logic       busy;
  logic       done;
  logic       match;
  logic       err_valid;
  logic [2:0] first_err;

  modport master (
    output start, f_in, expected,
    input  abc, tt, ones, busy, done, match, err_valid, first_err
  );

  modport slave (
    input  start, f_in, expected,
    output abc, tt, ones, busy, done, match, err_valid, first_err
  );
endinterface

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - walks abc through 000..111, samples a 3-input function into a truth table
module truth_table_scanner #(
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_scanner_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_abc;
  logic [7:0] r_tt;
  logic [3:0] r_ones;
  logic       r_match;
  logic       r_err_valid;
  logic [2:0] r_first_err;
  logic [3:0] r_cnt;
  logic [7:0] r_exp;
  logic       w_sample;
  logic       w_last;
  logic [7:0] w_tt_next;

  assign w_sample = (r_state == S_SCAN) && (r_cnt == 4'(SETTLE - 1));
  assign w_last   = (r_abc == 3'd7);

  // Table as it will look after this edge's sample; match is judged on it at DONE entry.
  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_abc] = bus.f_in;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SCAN;
      S_SCAN:  if (w_sample && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abc       <= 3'd0;
      r_tt        <= 8'd0;
      r_ones      <= 4'd0;
      r_match     <= 1'b0;
      r_err_valid <= 1'b0;
      r_first_err <= 3'd0;
      r_cnt       <= 4'd0;
      r_exp       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_exp       <= bus.expected;
            r_tt        <= 8'd0;
            r_ones      <= 4'd0;
            r_err_valid <= 1'b0;
            r_first_err <= 3'd0;
            r_cnt       <= 4'd0;
            r_abc       <= 3'd0;
          end
        end
        S_SCAN: begin
          if (w_sample) begin
            r_tt   <= w_tt_next;
            r_ones <= r_ones + {3'b000, bus.f_in};
            if ((bus.f_in != r_exp[r_abc]) && !r_err_valid) begin
              r_err_valid <= 1'b1;
              r_first_err <= r_abc;
            end
            if (w_last) begin
              r_match <= (w_tt_next == r_exp);
            end else begin
              r_abc <= r_abc + 3'd1;
              r_cnt <= 4'd0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: r_abc <= 3'd0;
        default: r_abc <= 3'd0;
      endcase
    end
  end

  assign bus.abc       = r_abc;
  assign bus.tt        = r_tt;
  assign bus.ones      = r_ones;
  assign bus.busy      = (r_state == S_SCAN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.match     = r_match;
  assign bus.err_valid = r_err_valid;
  assign bus.first_err = r_first_err;

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - scans directed and random 3-input functions on SETTLE=1,2,3 instances
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r_start [3];
  logic [7:0] r_exp   [3];
  logic [7:0] r_tbl   [3];
  int         r_fn    [3];

  logic [2:0] w_abc   [3];
  logic [7:0] w_tt    [3];
  logic [3:0] w_ones  [3];
  logic       w_busy  [3];
  logic       w_done  [3];
  logic       w_match [3];
  logic       w_err   [3];
  logic [2:0] w_ferr  [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // fn 0: A.B' + A.C   1: constant 1   2: arbitrary table   3: A.B'.C' + A.B'.C + A.B.C
  function automatic logic fn_val(input int fn, input logic [7:0] tbl, input logic [2:0] v);
    logic a, b, c;
    a = v[2];
    b = v[1];
    c = v[0];
    case (fn)
      0:       return (a & ~b) | (a & c);
      1:       return 1'b1;
      2:       return tbl[v];
      default: return (a & ~b & ~c) | (a & ~b & c) | (a & b & c);
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    truth_table_scanner_if u_if ();
    logic r_d1, r_d2;

    // fn 3 reaches f_in through two flops to model a slow function-under-test
    always @(posedge clk) begin
      r_d1 <= fn_val(3, 8'h00, u_if.abc);
      r_d2 <= r_d1;
    end

    assign u_if.start    = r_start[g];
    assign u_if.expected = r_exp[g];
    assign u_if.f_in     = (r_fn[g] == 3) ? r_d2 : fn_val(r_fn[g], r_tbl[g], u_if.abc);

    truth_table_scanner #(.SETTLE(g + 1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
    );

    assign w_abc[g]   = u_if.abc;
    assign w_tt[g]    = u_if.tt;
    assign w_ones[g]  = u_if.ones;
    assign w_busy[g]  = u_if.busy;
    assign w_done[g]  = u_if.done;
    assign w_match[g] = u_if.match;
    assign w_err[g]   = u_if.err_valid;
    assign w_ferr[g]  = u_if.first_err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while ((w_busy[k] || w_done[k]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 32'(t), 32'd0);
  endtask

  task automatic run_scan(input int k, input int fn, input logic [7:0] tbl,
                          input logic [7:0] exp_v, input bit hold);
    int s, busy_cnt, done_cnt, done_at, abc_bad, exp_abc;
    logic [7:0] m_tt, d_tt, held_tt;
    logic [3:0] m_ones;
    logic [2:0] m_first;
    logic       m_err;
    s = k + 1;
    for (int i = 0; i < 8; i++) m_tt[i] = fn_val(fn, tbl, 3'(i));
    m_ones  = 4'($countones(m_tt));
    m_err   = (m_tt != exp_v);
    m_first = 3'd0;
    for (int i = 7; i >= 0; i--) if (m_tt[i] != exp_v[i]) m_first = 3'(i);
    busy_cnt = 0; done_cnt = 0; done_at = -1; abc_bad = 0;
    d_tt = 8'h00; held_tt = 8'h00;

    @(negedge clk);
    r_fn[k] = fn; r_tbl[k] = tbl; r_exp[k] = exp_v; r_start[k] = 1'b1;
    @(posedge clk);
    for (int kk = 0; kk <= 8 * s + 2; kk++) begin
      @(negedge clk);
      if (!hold) r_start[k] = 1'b0;
      if (w_busy[k]) busy_cnt++;
      if (kk < 8 * s)       exp_abc = kk / s;
      else if (kk == 8 * s) exp_abc = 7;
      else                  exp_abc = 0;
      if (int'(w_abc[k]) != exp_abc) abc_bad++;
      if (w_done[k]) begin
        done_cnt++;
        done_at = kk;
        d_tt = w_tt[k];
        chk("ones", 32'(w_ones[k]), 32'(m_ones));
        chk("match", 32'(w_match[k]), 32'(!m_err));
        chk("err_valid", 32'(w_err[k]), 32'(m_err));
        chk("first_err", 32'(w_ferr[k]), 32'(m_first));
        chk("busy_in_done", 32'(w_busy[k]), 32'd0);
      end
      if (kk == 8 * s + 1) held_tt = w_tt[k];
      if (kk == 8 * s + 2) begin
        chk("restart_busy", 32'(w_busy[k]), 32'(hold));
        chk("tt_after", 32'(w_tt[k]), hold ? 32'd0 : 32'(m_tt));
        chk("err_after", 32'(w_err[k]), hold ? 32'd0 : 32'(m_err));
      end
    end
    chk("tt", 32'(d_tt), 32'(m_tt));
    chk("tt_held", 32'(held_tt), 32'(m_tt));
    chk("busy_cycles", 32'(busy_cnt), 32'(8 * s + (hold ? 1 : 0)));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_at", 32'(done_at), 32'(8 * s));
    chk("abc_seq", 32'(abc_bad), 32'd0);
    r_start[k] = 1'b0;
    wait_idle(k);
  endtask

  task automatic reset_mid_scan(input int k);
    int t;
    @(negedge clk);
    r_fn[k] = 1; r_exp[k] = 8'h00; r_start[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_start[k] = 1'b0;
    t = 0;
    while (w_abc[k] != 3'd3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach_abc3", 32'(w_abc[k]), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_abc", 32'(w_abc[k]), 32'd0);
    chk("rst_tt", 32'(w_tt[k]), 32'd0);
    chk("rst_flags", {27'd0, w_busy[k], w_done[k], w_match[k], w_err[k], |w_ones[k]}, 32'd0);
    chk("rst_first_err", 32'(w_ferr[k]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {30'd0, w_busy[k], w_done[k]}, 32'd0);
    chk("post_rst_abc", 32'(w_abc[k]), 32'd0);
  endtask

  initial begin
    int k, fn;
    logic [7:0] tbl, ev;
    for (int g = 0; g < 3; g++) begin
      r_start[g] = 1'b0; r_exp[g] = 8'h00; r_tbl[g] = 8'h00; r_fn[g] = 0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_abc", 32'(w_abc[g]), 32'd0);
      chk("reset_state", {20'd0, w_tt[g], w_busy[g], w_done[g], w_match[g], w_err[g]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(1, 0, 8'h00, 8'hB0, 1'b0);
    run_scan(1, 0, 8'h00, 8'hB1, 1'b0);
    run_scan(0, 1, 8'h00, 8'h00, 1'b0);
    run_scan(1, 0, 8'h00, 8'hB0, 1'b1);
    reset_mid_scan(1);
    run_scan(2, 3, 8'h00, 8'hB0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      k   = $urandom_range(0, 2);
      tbl = 8'($urandom);
      fn  = ($urandom_range(0, 3) == 0) ? 0 : 2;
      if (k == 2 && $urandom_range(0, 3) == 0) fn = 3;
      ev  = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) ev[i] = fn_val(fn, tbl, 3'(i));
      end
      run_scan(k, fn, tbl, ev, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
